nibble_serial_adder: RTL and testbench

Multi-word adder sequencer: a single instance of the codebase's 4-bit `ripple_carry` adder is time-shared across the nibbles of a wide operand pair, least-significant nibble first. A carry register chains each nibble to the next. The block sits between a requesting controller (start/ack handshake) and a result consumer. It trades latency for reusing one small adder instead of instantiating a wide one.

---
 rtl/nibble_serial_adder_if.sv | 41 ++++
 rtl/nibble_serial_adder.sv | 136 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - request/result bundle for nibble_serial_adder
// The sub signal exists only when NIBBLE_ADDER_SUB_EN is defined.
interface nibble_serial_adder_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef NIBBLE_ADDER_SUB_EN
   logic         sub;
`endif
   logic         ack;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

`ifdef NIBBLE_ADDER_SUB_EN
   modport master (
      output start, a, b, cin, sub, ack,
      input  ready, busy, done, sum, cout
   );
   modport slave (
      input  start, a, b, cin, sub, ack,
      output ready, busy, done, sum, cout
   );
`else
   modport master (
      output start, a, b, cin, ack,
      input  ready, busy, done, sum, cout
   );
   modport slave (
      input  start, a, b, cin, ack,
      output ready, busy, done, sum, cout
   );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - wide adder sequenced through one 4-bit ripple_carry, LS nibble first
// Define NIBBLE_ADDER_SUB_EN to add the a - b mode selected by sub.
module ripple_carry (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [4:0] c;

   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[4];
   end
endmodule

module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   nibble_serial_adder_if.slave bus
);
   localparam int W    = 4 * NIBBLES;
   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic [IDXW-1:0] idx_q, idx_d;

   logic [W-1:0]    b_in;
   logic            carry_in;
   logic [3:0]      nib_a, nib_b, nib_s;
   logic            nib_cout;

   // Subtraction folds into the operand capture: store ~b and seed the carry with 1.
`ifdef NIBBLE_ADDER_SUB_EN
   assign b_in     = bus.sub ? ~bus.b : bus.b;
   assign carry_in = bus.sub | bus.cin;
`else
   assign b_in     = bus.b;
   assign carry_in = bus.cin;
`endif

   assign nib_a = a_q[{idx_q, 2'b00} +: 4];
   assign nib_b = b_q[{idx_q, 2'b00} +: 4];

   ripple_carry u_adder (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .s    (nib_s),
      .cout (nib_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = b_in;
               carry_d = carry_in;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[{idx_q, 2'b00} +: 4] = nib_s;
            carry_d = nib_cout;
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               cout_d  = nib_cout;
               idx_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.ack) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.ready = (state_q == S_IDLE);
   assign bus.busy  = (state_q == S_RUN);
   assign bus.done  = (state_q == S_DONE);
   assign bus.sum   = sum_q;
   assign bus.cout  = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed bench with arithmetic reference model for nibble_serial_adder
module tb_nibble_serial_adder;
   localparam int N = 4;
   localparam int W = 4 * N;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   nibble_serial_adder_if #(.NIBBLES(N)) bus ();
   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: true (W+1)-bit result plus how many nibbles have been exposed.
   bit           cmp_en = 0;
   bit           m_ready, m_busy, m_done, m_clean;
   int           m_k;
   logic [W:0]   m_full;

   initial forever begin
      @(posedge clk);
      if (reset) begin
         m_ready = 1; m_busy = 0; m_done = 0; m_clean = 1; m_k = 0;
         cmp_en  = 1;
      end else if (m_ready && bus.start) begin
         m_full = {1'b0, bus.a} + {1'b0, bus.b} + (W + 1)'(bus.cin);
`ifdef NIBBLE_ADDER_SUB_EN
         if (bus.sub) m_full = {1'b0, bus.a} + {1'b0, ~bus.b} + (W + 1)'(1);
`endif
         m_ready = 0; m_busy = 1; m_k = 0; m_clean = 0;
      end else if (m_busy) begin
         m_k++;
         if (m_k == N) begin
            m_busy = 0; m_done = 1;
         end
      end else if (m_done && bus.ack) begin
         m_done = 0; m_ready = 1;
      end
   end

   initial forever begin
      logic [W-1:0] msk;
      @(negedge clk);
      if (cmp_en) begin
         chk("m_ready", bus.ready, m_ready);
         chk("m_busy", bus.busy, m_busy);
         chk("m_done", bus.done, m_done);
         if (m_busy) begin
            msk = W'((64'd1 << (4 * m_k)) - 64'd1);
            chk("m_sum_partial", bus.sum, m_full[W-1:0] & msk);
         end
         if (m_done) begin
            chk("m_sum", bus.sum, m_full[W-1:0]);
            chk("m_cout", bus.cout, m_full[W]);
         end
         if (m_ready && m_clean) begin
            chk("m_sum_clean", bus.sum, 0);
            chk("m_cout_clean", bus.cout, 0);
         end
      end
   end

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input bit poke, output int lat);
      bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
`ifdef NIBBLE_ADDER_SUB_EN
      bus.sub = s;
`else
      if (s) bus.cin = c;
`endif
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (poke && lat == 1) begin
            bus.start = 1'b1; bus.a = 16'hAAAA;
         end else if (poke && lat == 2) begin
            bus.start = 1'b0; bus.a = a;
         end
      end
      chk("done_seen", bus.done, 1);
   endtask

   task automatic do_ack();
      bus.ack = 1'b1;
      @(posedge clk); #1;
      bus.ack = 1'b0;
      chk("ack_ready", bus.ready, 1);
      chk("ack_done_low", bus.done, 0);
   endtask

   task automatic chk_res(input string name, input int lat, input logic [W-1:0] es, input logic ec);
      chk({name, "_lat"}, lat, N);
      chk({name, "_sum"}, bus.sum, es);
      chk({name, "_cout"}, bus.cout, ec);
   endtask

   initial begin
      int lat;
      reset = 1'b1; bus.start = 0; bus.a = 0; bus.b = 0; bus.cin = 0; bus.ack = 0;
`ifdef NIBBLE_ADDER_SUB_EN
      bus.sub = 0;
`endif
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_ready", bus.ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_sum", bus.sum, 0);
      chk("rst_cout", bus.cout, 0);

      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, lat);
      chk_res("add1", lat, 16'h5555, 1'b0);
      do_ack();

      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, lat);
      chk_res("carry_chain", lat, 16'h0000, 1'b1);
      do_ack();

      run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1, lat);
      chk_res("cin_ignore_start", lat, 16'h0001, 1'b0);
      do_ack();

      run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0, lat);
      chk_res("hold", lat, 16'h1010, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("hold_done", bus.done, 1);
         chk("hold_sum", bus.sum, 16'h1010);
         chk("hold_cout", bus.cout, 0);
      end
      do_ack();
      run_op(16'h9999, 16'h9999, 1'b0, 1'b0, 0, lat);
      chk_res("b2b", lat, 16'h3332, 1'b1);
      do_ack();

      bus.a = 16'h8888; bus.b = 16'h8888; bus.cin = 0; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("abort_ready", bus.ready, 1);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_sum", bus.sum, 0);
      chk("abort_cout", bus.cout, 0);
      run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0, lat);
      chk_res("after_abort", lat, 16'h0007, 1'b0);
      do_ack();

`ifdef NIBBLE_ADDER_SUB_EN
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, lat);
      chk_res("sub_borrow", lat, 16'hFFFE, 1'b0);
      do_ack();
      run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, lat);
      chk_res("sub_noborrow", lat, 16'h0002, 1'b1);
      do_ack();
      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, lat);
      chk_res("sub0_add", lat, 16'h5555, 1'b0);
      do_ack();
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
